// File: rtl/beam_delay_scheduler.sv
// rtl/beam_delay_scheduler.sv - per-channel delay-table scan and delay-and-sum accumulator
// Optional: define BEAM_SIGNED_SAMPLES_EN to treat sample_in as two's complement.
module beam_delay_scheduler #(
    parameter int NUM_CHANNELS        = 8,
    parameter int NUMBER_OF_BITS      = 8,
    parameter int SAMPLES_BUFFER_SIZE = 10,
    localparam int IDX_W = $clog2(SAMPLES_BUFFER_SIZE) + 1,
    localparam int CH_W  = $clog2(NUM_CHANNELS),
    localparam int SUM_W = NUMBER_OF_BITS + CH_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_tick,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [IDX_W-1:0]          cfg_delay,
    output logic [CH_W-1:0]           ch_sel,
    output logic [IDX_W-1:0]          read_index,
    input  logic [NUMBER_OF_BITS-1:0] sample_in,
    output logic [SUM_W-1:0]          sum_out,
    output logic                      sum_valid,
    output logic                      busy,
    output logic                      overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    localparam logic [IDX_W-1:0] MAX_DELAY = IDX_W'(SAMPLES_BUFFER_SIZE - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CHANNELS - 1);

    state_t           state;
    logic [CH_W-1:0]  k;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] sample_ext;
    logic [IDX_W-1:0] cfg_clamped;
    logic [IDX_W-1:0] pend_tbl  [NUM_CHANNELS];
    logic [IDX_W-1:0] pend_next [NUM_CHANNELS];
    logic [IDX_W-1:0] act_tbl   [NUM_CHANNELS];

    assign cfg_clamped = (cfg_delay > MAX_DELAY) ? MAX_DELAY : cfg_delay;

`ifdef BEAM_SIGNED_SAMPLES_EN
    assign sample_ext = {{CH_W{sample_in[NUMBER_OF_BITS-1]}}, sample_in};
`else
    assign sample_ext = {{CH_W{1'b0}}, sample_in};
`endif

    // The snapshot taken on an accepted tick must see a same-cycle write.
    always_comb begin
        pend_next = pend_tbl;
        if (cfg_we) begin
            pend_next[cfg_ch] = cfg_clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            acc        <= '0;
            ch_sel     <= '0;
            read_index <= '0;
            sum_out    <= '0;
            sum_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                pend_tbl[i] <= '0;
                act_tbl[i]  <= '0;
            end
        end else begin
            pend_tbl  <= pend_next;
            sum_valid <= 1'b0;
            if (sample_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        act_tbl <= pend_next;
                        acc     <= '0;
                        k       <= '0;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    ch_sel     <= k;
                    read_index <= act_tbl[k];
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    acc <= acc + sample_ext;
                    if (k == LAST_CH) begin
                        state <= DONE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    sum_out   <= acc;
                    sum_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
